spi_flash_dual_reader: RTL
==========================

Name: spi_flash_dual_reader

Overview:
- Synthesizable SPI mode-0 initiator that fetches a block of bytes from external SPI flash using the dual-output fast-read command.
- Frame: opcode, 24-bit address, dummy byte, then data returned two bits per SCK on {MISO, MOSI}.
- Serves as the boot/data loader for the iCE40 code and data images, at 0x03_0000 and 0x05_0000.
- Delivers bytes on a valid/ready stream. Pad tristating is external (SB_IO).

Parameters:
- OPCODE, 8'h3B, read command sent MSB first.
- CS_HIGH_CYC, 4, minimum clk cycles cs_n stays high between frames.
- LEN_W, 16, width of the byte-count field.

Ports:
- clk  in  1  system clock; SCK = clk/2.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  1  read request.
- req_ready  out  1  high when idle, guard satisfied and rd_valid==0.
- req_addr  in  24  flash start byte address.
- req_len  in  LEN_W  bytes to read; 0 is legal.
- rd_data  out  8  returned byte.
- rd_valid  out  1  rd_data valid.
- rd_ready  in  1  consumer accepts rd_data.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse when a request completes.
- spi_cs_n  out  1  chip select, active low.
- spi_sck  out  1  serial clock, idle low.
- spi_mosi_o  out  1  MOSI output value.
- spi_mosi_oe  out  1  MOSI output enable.
- spi_mosi_i  in  1  MOSI pad input (data bit 6/4/2/0).
- spi_miso_i  in  1  MISO pad input (data bit 7/5/3/1).

Behaviour:
- Reset values (resetn low, asynchronous): spi_cs_n=1, spi_sck=0, spi_mosi_oe=0, spi_mosi_o=0, rd_valid=0, rd_data=0, busy=0, done=0.
- After reset the block is in IDLE; req_ready=1 once resetn releases.
- All outputs are registered except req_ready.
- States: IDLE, CMD, DUMMY, DATA, HOLD, GUARD.
- Accept: req_valid && req_ready at edge T; addr and len are latched.
- len==0: no SPI activity; done pulses at T+1; state stays IDLE.
- CMD (len>0): at T+1, cs_n=0, sck=0, mosi_oe=1, mosi_o=OPCODE[7].
  - SCK toggles every clk, so rising edge n occurs at T+2n.
  - mosi_o changes only on the clk edge that drives sck low.
  - 32 bits are shifted: OPCODE, then addr[23:0], MSB first.
- DUMMY: rising edges 33..40. mosi_oe=0 from the falling edge after edge 32; mosi_o is don't-care.
- DATA: 4 rising edges per byte.
  - At each rising edge, {spi_miso_i, spi_mosi_i} is sampled at that clk edge as the next two bits, MSB first: bits [7:6], then [5:4], [3:2], [1:0].
  - At the 4th edge the byte loads rd_data and rd_valid=1. First byte appears at T+88; with rd_ready=1 continuously, byte k appears at T+88+8k.
- Output handshake: rd_valid clears on rd_valid && rd_ready unless a new byte loads on the same edge.
- HOLD (backpressure): a new data byte's first rising edge is issued only if rd_valid==0, or rd_ready==1 in that cycle.
  - Otherwise sck stays low and cs_n stays low until the condition holds.
  - No byte is dropped or duplicated.
- End of frame: after the last byte's 4th rising edge E:
  - sck=0 at E+1.
  - cs_n=1, busy=0 and done=1 at E+2.
  - GUARD then lasts CS_HIGH_CYC cycles.
  - req_ready stays low until GUARD has ended and the final byte is consumed.
- busy=1 from T+1 until cs_n rises.
- Requests while not ready are ignored; there is no queueing.
- The byte counter decrements per delivered byte. Address auto-increment and wrap are the flash's responsibility.
- Reset mid-frame: cs_n rises immediately and the partial byte is discarded.

Test Plan:
- Reset: hold resetn low 5 cycles, then release -> cs_n=1, sck=0, mosi_oe=0, rd_valid=0, done=0, req_ready=1.
- Read addr=24'h030000, len=4, against the dual-mode flash model, rd_ready=1:
  - MOSI carries 0x3B then 0x03,0x00,0x00 while oe=1.
  - oe drops before dummy.
  - rd_valid at T+88/96/104/112 with bytes equal to the model mem at 0x030000..3.
  - done at T+114.
- Backpressure: len=3 at 0x050000, rd_ready low for 20 cycles after the first byte -> sck held low, cs_n low, all 3 bytes correct and in order.
- len=0 -> done at T+1, cs_n never falls, req_ready stays 1.
- Reset mid-DATA (after 2 of 8 bytes): resetn low -> cs_n=1 immediately. A follow-up len=2 request then returns correct bytes.
- Back-to-back: req_valid held high across two len=1 requests -> the second is accepted only after cs_n has been high for ≥4 cycles and rd_valid has cleared; no other accept occurs while busy.

Source files
------------

// File: rtl/spi_flash_dual_reader.sv
// SPI mode-0 dual-output fast-read (0x3B) initiator: streams a block of flash bytes
// out on a valid/ready interface. SCK runs at clk/2; pad tristating lives outside.
module spi_flash_dual_reader #(
    parameter logic [7:0]  OPCODE      = 8'h3B,
    parameter int unsigned CS_HIGH_CYC = 4,
    parameter int unsigned LEN_W       = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [23:0]      req_addr,
    input  logic [LEN_W-1:0] req_len,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic             busy,
    output logic             done,
    output logic             spi_cs_n,
    output logic             spi_sck,
    output logic             spi_mosi_o,
    output logic             spi_mosi_oe,
    input  logic             spi_mosi_i,
    input  logic             spi_miso_i
);

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StDummy,
        StData,
        StHold,
        StGuard
    } state_e;

    state_e           state_q, state_d;
    logic             start_q, start_d;
    logic [23:0]      addr_q, addr_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [31:0]      sh_q, sh_d;
    logic [5:0]       edge_q, edge_d;
    logic [1:0]       pair_q, pair_d;
    logic [5:0]       dsh_q, dsh_d;
    logic [7:0]       guard_q, guard_d;
    logic             cs_n_q, cs_n_d;
    logic             sck_q, sck_d;
    logic             mosi_o_q, mosi_o_d;
    logic             mosi_oe_q, mosi_oe_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             can_issue;
    logic             data_rise;
    logic [1:0]       sample;

    // A request latched but not yet launched blocks further accepts, except len==0 which
    // completes without touching the bus.
    assign req_ready = (state_q == StIdle) && !(start_q && (len_q != '0)) && !rd_valid_q;
    assign can_issue = !rd_valid_q || rd_ready;
    assign sample    = {spi_miso_i, spi_mosi_i};

    always_comb begin
        state_d    = state_q;
        start_d    = start_q;
        addr_d     = addr_q;
        len_d      = len_q;
        rem_d      = rem_q;
        sh_d       = sh_q;
        edge_d     = edge_q;
        pair_d     = pair_q;
        dsh_d      = dsh_q;
        guard_d    = guard_q;
        cs_n_d     = cs_n_q;
        sck_d      = sck_q;
        mosi_o_d   = mosi_o_q;
        mosi_oe_d  = mosi_oe_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        data_rise  = 1'b0;

        if (rd_valid_q && rd_ready) begin
            rd_valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (start_q) begin
                    start_d = 1'b0;
                    if (len_q == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d   = StCmd;
                        cs_n_d    = 1'b0;
                        sck_d     = 1'b0;
                        busy_d    = 1'b1;
                        mosi_oe_d = 1'b1;
                        mosi_o_d  = OPCODE[7];
                        sh_d      = {OPCODE[6:0], addr_q, 1'b0};
                        edge_d    = 6'd0;
                        rem_d     = len_q;
                    end
                end
                if (req_valid && req_ready) begin
                    start_d = 1'b1;
                    addr_d  = req_addr;
                    len_d   = req_len;
                end
            end

            StCmd: begin
                if (!sck_q) begin
                    sck_d  = 1'b1;
                    edge_d = edge_q + 6'd1;
                end else begin
                    // MOSI only moves while SCK is driven low (mode 0).
                    sck_d = 1'b0;
                    if (edge_q == 6'd32) begin
                        mosi_oe_d = 1'b0;
                        state_d   = StDummy;
                    end else begin
                        mosi_o_d = sh_q[31];
                        sh_d     = {sh_q[30:0], 1'b0};
                    end
                end
            end

            StDummy: begin
                if (!sck_q) begin
                    sck_d  = 1'b1;
                    edge_d = edge_q + 6'd1;
                end else begin
                    sck_d = 1'b0;
                    if (edge_q == 6'd40) begin
                        state_d = StData;
                        pair_d  = 2'd0;
                    end
                end
            end

            StData: begin
                if (sck_q) begin
                    sck_d = 1'b0;
                end else if (rem_q == '0) begin
                    cs_n_d = 1'b1;
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    if (CS_HIGH_CYC == 0) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StGuard;
                        guard_d = 8'(CS_HIGH_CYC - 1);
                    end
                end else if ((pair_q == 2'd0) && !can_issue) begin
                    state_d = StHold;
                end else begin
                    data_rise = 1'b1;
                end
            end

            StHold: begin
                if (can_issue) begin
                    data_rise = 1'b1;
                    state_d   = StData;
                end
            end

            StGuard: begin
                if (guard_q == 8'd0) begin
                    state_d = StIdle;
                end else begin
                    guard_d = guard_q - 8'd1;
                end
            end

            default: state_d = StIdle;
        endcase

        // Pins are sampled on the same clk edge that raises SCK; the flash shifted them
        // out on the previous falling edge.
        if (data_rise) begin
            sck_d  = 1'b1;
            dsh_d  = {dsh_q[3:0], sample};
            pair_d = pair_q + 2'd1;
            if (pair_q == 2'd3) begin
                rd_data_d  = {dsh_q, sample};
                rd_valid_d = 1'b1;
                rem_d      = rem_q - {{(LEN_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            start_q    <= 1'b0;
            addr_q     <= 24'd0;
            len_q      <= '0;
            rem_q      <= '0;
            sh_q       <= 32'd0;
            edge_q     <= 6'd0;
            pair_q     <= 2'd0;
            dsh_q      <= 6'd0;
            guard_q    <= 8'd0;
            cs_n_q     <= 1'b1;
            sck_q      <= 1'b0;
            mosi_o_q   <= 1'b0;
            mosi_oe_q  <= 1'b0;
            rd_data_q  <= 8'd0;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            rem_q      <= rem_d;
            sh_q       <= sh_d;
            edge_q     <= edge_d;
            pair_q     <= pair_d;
            dsh_q      <= dsh_d;
            guard_q    <= guard_d;
            cs_n_q     <= cs_n_d;
            sck_q      <= sck_d;
            mosi_o_q   <= mosi_o_d;
            mosi_oe_q  <= mosi_oe_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign spi_cs_n    = cs_n_q;
    assign spi_sck     = sck_q;
    assign spi_mosi_o  = mosi_o_q;
    assign spi_mosi_oe = mosi_oe_q;
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
